rr_arb8_ctrl: RTL



---
 rtl/rr_arb8_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rr_arb8_ctrl.sv
// rr_arb8_ctrl
//   Round-robin arbiter for eight requesters sharing one downstream resource.
//   A winner is picked from req with rotating priority (ptr is the highest
//   priority index). The grant is held until the owner pulses done or drops
//   its request. At least one IDLE cycle always separates two grants.
//
// Optional feature (compile-time macro RR_ARB8_TIMEOUT_EN):
//   Revokes a grant that has been held for HOLD_MAX cycles. The timeout
//   output pulses for one cycle after the revoke. Without the macro there is
//   no hold counter and timeout is tied low.
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   en       arbitration enable (blocks new grants only)
//   req      request vector, bit i = requester i
//   done     owner release strobe, only looked at while a grant is held
//   gnt      registered one-hot grant, 8'h00 when nobody owns the resource
//   gnt_idx  registered index of the current (or last) owner
//   gnt_vld  1 while a grant is held
//   timeout  one-cycle pulse after a forced revoke
module rr_arb8_ctrl #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [7:0] gnt_nxt;
  logic [2:0] idx_nxt;
  logic       vld_nxt;

  logic [2:0] cand;
  logic [2:0] win_idx;
  logic       win_vld;
  logic       owner_rel;
  logic       to_hit;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arb8_ctrl: HOLD_MAX must be in 2..255");
  end

  // Rotating-priority scan. Walking the offsets from 7 down to 0 lets the
  // smallest offset from ptr overwrite any later candidate, so the first set
  // bit at or after ptr wins.
  always_comb begin
    cand    = ptr;
    win_idx = ptr;
    win_vld = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  // done and a request drop in the same cycle are one release.
  assign owner_rel = done | ~req[gnt_idx];

`ifdef RR_ARB8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_cnt;

  assign to_hit = (state == GRANT) && (hold_cnt == HOLD_LAST);

  // The counter sits at 0 throughout IDLE, so it reads 0 in the first GRANT
  // cycle and HOLD_MAX-1 in the last one allowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_hit & ~owner_rel;
      if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end else begin
        hold_cnt <= 8'd0;
      end
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
    case (state)
      IDLE: begin
        if (en && win_vld) begin
          state_nxt = GRANT;
          idx_nxt   = win_idx;
          gnt_nxt   = 8'd1 << win_idx;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (owner_rel || to_hit) begin
          state_nxt = IDLE;
          gnt_nxt   = 8'h00;
          vld_nxt   = 1'b0;
          ptr_nxt   = gnt_idx + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 8'h00;
        vld_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
    end
  end

endmodule
